// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, fetches through a
// single-cycle ready handshake and feeds the decoder. Optional counters under FETCH_PERF_EN.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] ifid_out,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_q, buf_d;
  logic        load_inst, load_bubble;
  logic [31:0] pc_plus4, target;

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = {redirect_pc[31:2], 2'b00};

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_d       = buf_q;
    load_inst   = 1'b0;
    load_bubble = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (flush) pc_d = target;
      end
      FETCH: begin
        if (flush) begin
          pc_d        = target;
          ir_d        = 32'h0;
          valid_d     = 1'b0;
          load_bubble = 1'b1;
        end else if (imem_ready && !stall) begin
          ir_d      = imem_rdata;
          pc4_d     = pc_plus4;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          load_inst = 1'b1;
        end else if (imem_ready) begin
          // Word arrived while ID is stalled: park it so it is not refetched.
          buf_d   = imem_rdata;
          state_d = HOLD;
        end else if (!stall) begin
          ir_d        = 32'h0;
          valid_d     = 1'b0;
          load_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d        = target;
          ir_d        = 32'h0;
          valid_d     = 1'b0;
          buf_d       = 32'h0;
          state_d     = FETCH;
          load_bubble = 1'b1;
        end else if (!stall) begin
          ir_d      = buf_q;
          pc4_d     = pc_plus4;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          state_d   = FETCH;
          load_inst = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == FETCH);
  assign pc         = pc_q;
  assign ifid_out   = ir_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (load_inst)   fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  logic unused_load_flags;
  assign unused_load_flags = load_inst ^ load_bubble;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage: directed scenarios with literal expectations,
// then randomized stall/flush/ready traffic compared every cycle against a behavioural model.
module tb_fetch_ifid_stage;

  logic        clk;
  logic        clrn;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic        imem_req, imem_ready, stall, flush;
  logic [31:0] pc, ifid_out, ifid_pc4;
  logic        ifid_valid;

  // Second instance with a wrapping reset PC, always ready, never stalled.
  logic [31:0] b_addr, b_rdata, b_pc, b_out, b_pc4;
  logic        b_req, b_valid;
  logic        one, zero;
  logic [31:0] zero32;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt, b_pf, b_pb;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign b_rdata    = mem_word(b_addr);
  assign one    = 1'b1;
  assign zero   = 1'b0;
  assign zero32 = 32'h0;

  fetch_ifid_stage dut (
    .clk(clk), .clrn(clrn), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc), .pc(pc), .ifid_out(ifid_out), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  fetch_ifid_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .clrn(clrn), .imem_addr(b_addr), .imem_req(b_req),
    .imem_rdata(b_rdata), .imem_ready(one), .stall(zero), .flush(zero),
    .redirect_pc(zero32), .pc(b_pc), .ifid_out(b_out), .ifid_pc4(b_pc4),
    .ifid_valid(b_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(b_pf), .perf_bubble_cnt(b_pb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the fetch unit is "started" one cycle after reset; a word that
  // arrives during a stall is kept in a one-entry queue until ID can accept it.
  typedef struct {
    logic [31:0] word;
    logic [31:0] pc4;
  } held_t;

  held_t       held[$];
  bit          m_started;
  logic [31:0] m_pc, m_out, m_pc4, m_fetch, m_bubble;
  logic        m_valid;

  function automatic void model_reset();
    held.delete();
    m_started = 0;
    m_pc      = 32'h0;
    m_out     = 32'h0;
    m_pc4     = 32'h0;
    m_valid   = 1'b0;
    m_fetch   = 32'h0;
    m_bubble  = 32'h0;
  endfunction

  function automatic void deliver(input logic [31:0] word, input logic [31:0] pc4);
    m_out   = word;
    m_pc4   = pc4;
    m_valid = 1'b1;
    m_pc    = m_pc + 32'd4;
    m_fetch = m_fetch + 32'd1;
  endfunction

  function automatic void insert_bubble();
    m_out    = 32'h0;
    m_valid  = 1'b0;
    m_bubble = m_bubble + 32'd1;
  endfunction

  function automatic void model_step();
    if (!m_started) begin
      m_started = 1;
      if (flush) m_pc = redirect_pc & ~32'h3;
    end else if (flush) begin
      m_pc = redirect_pc & ~32'h3;
      held.delete();
      insert_bubble();
    end else if (held.size() != 0) begin
      if (!stall) begin
        deliver(held[0].word, held[0].pc4);
        held.delete();
      end
    end else if (imem_ready) begin
      if (stall) held.push_back('{word: mem_word(m_pc), pc4: m_pc + 32'd4});
      else       deliver(mem_word(m_pc), m_pc + 32'd4);
    end else if (!stall) begin
      insert_bubble();
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (clrn) model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc", pc, m_pc);
      check("imem_addr", imem_addr, m_pc);
      check("imem_req", {31'h0, imem_req}, {31'h0, (m_started && held.size() == 0)});
      check("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
      check("ifid_out", ifid_out, m_out);
      if (m_valid) check("ifid_pc4", ifid_pc4, m_pc4);
`ifdef FETCH_PERF_EN
      check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
      check("perf_bubble_cnt", perf_bubble_cnt, m_bubble);
`endif
    end
  end

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ready  = ($urandom_range(3) != 0);
      stall       = ($urandom_range(3) == 0);
      flush       = ($urandom_range(9) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(15) == 0) redirect_pc = 32'hFFFF_FFF8 | (redirect_pc & 32'h3);
      tick();
    end
  endtask

  initial begin
    clrn = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b1; redirect_pc = 32'h0;
    model_reset();
    cmp_en = 1;
    @(posedge clk); #1;
    clrn = 1'b1;

    // Cycle 1: idle after reset release.
    @(negedge clk);
    check("c1 req", {31'h0, imem_req}, 32'h0);
    check("c1 pc", pc, 32'h0);
    tick();
    @(negedge clk);
    check("c2 addr", imem_addr, 32'h0);
    check("c2 req", {31'h0, imem_req}, 32'h1);
    check("wrap c2 addr", b_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("c3 addr", imem_addr, 32'h4);
    check("c3 out", ifid_out, 32'h1357_FFFF);
    check("c3 pc4", ifid_pc4, 32'h4);
    check("c3 valid", {31'h0, ifid_valid}, 32'h1);
    check("wrap c3 out", b_out, 32'hECAB_0003);
    check("wrap c3 pc4", b_pc4, 32'h0);
    check("wrap c3 addr", b_addr, 32'h0);
    tick();
    @(negedge clk);
    check("c4 addr", imem_addr, 32'h8);
    check("c4 out", ifid_out, 32'h1353_FFFB);

    // Stall three cycles at pc=8.
    stall = 1'b1;
    tick();
    @(negedge clk);
    check("hold pc", pc, 32'h8);
    check("hold req", {31'h0, imem_req}, 32'h0);
    check("hold out", ifid_out, 32'h1353_FFFB);
    tick();
    tick();
    stall = 1'b0;
    tick();
    @(negedge clk);
    check("release out", ifid_out, 32'h135F_FFF7);
    check("release pc4", ifid_pc4, 32'hC);
    check("release pc", pc, 32'hC);

    // Flush wins over stall; target is word-aligned.
    stall = 1'b1; flush = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    @(negedge clk);
    check("flush pc", pc, 32'h100);
    check("flush out", ifid_out, 32'h0);
    check("flush valid", {31'h0, ifid_valid}, 32'h0);
    stall = 1'b0; flush = 1'b0;
    tick();
    @(negedge clk);
    check("target out", ifid_out, 32'h1257_FEFF);
    check("target pc", pc, 32'h104);

    // Memory not ready for two cycles at 0x20.
    flush = 1'b1; redirect_pc = 32'h20;
    tick();
    flush = 1'b0; imem_ready = 1'b0;
    tick();
    @(negedge clk);
    check("nr1 pc", pc, 32'h20);
    check("nr1 valid", {31'h0, ifid_valid}, 32'h0);
    tick();
    @(negedge clk);
    check("nr2 pc", pc, 32'h20);
    check("nr2 valid", {31'h0, ifid_valid}, 32'h0);
    imem_ready = 1'b1;
    tick();
    @(negedge clk);
    check("nr out", ifid_out, 32'h1377_FFDF);
    check("nr pc", pc, 32'h24);
`ifdef FETCH_PERF_EN
    check("perf fetch directed", perf_fetch_cnt, 32'd5);
    check("perf bubble directed", perf_bubble_cnt, 32'd4);
`endif

    random_cycles(1500);

    // Asynchronous reset in the middle of a HOLD cycle.
    imem_ready = 1'b1; stall = 1'b1; flush = 1'b0;
    tick();
    tick();
    #2;
    clrn = 1'b0;
    model_reset();
    #1;
    check("arst pc", pc, 32'h0);
    check("arst req", {31'h0, imem_req}, 32'h0);
    check("arst valid", {31'h0, ifid_valid}, 32'h0);
    check("arst out", ifid_out, 32'h0);
`ifdef FETCH_PERF_EN
    check("arst perf fetch", perf_fetch_cnt, 32'h0);
    check("arst perf bubble", perf_bubble_cnt, 32'h0);
`endif
    stall = 1'b0;
    tick();
    clrn = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("post-arst out", ifid_out, 32'h1357_FFFF);

    random_cycles(1500);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
